rng_key_sequencer: RTL and testbench



---
 rtl/rng_key_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_rng_key_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rng_key_sequencer.sv
// Push-button front end for the RNG: conditions three raw keys and sequences the
// LFSR datapath through seed load, free run, stop and result display.
module rng_key_sequencer #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MIN_RUN_CYCLES  = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_start,
  input  logic             key_stop,
  input  logic             key_clear,
  output logic             lfsr_load,
  output logic             lfsr_enable,
  output logic [WIDTH-1:0] seed_out,
  output logic             result_latch,
  output logic             result_valid,
  output logic [2:0]       state_out
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int RUN_W = $clog2(MIN_RUN_CYCLES + 1);
  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MIN_RUN_CYCLES);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEED     = 3'd1,
    RUN      = 3'd2,
    STOPPING = 3'd3,
    SHOW     = 3'd4
  } state_t;

  // Key bit order everywhere: [0]=start, [1]=stop, [2]=clear.
  logic [2:0]      w_keys;
  logic [2:0]      r_sync1;
  logic [2:0]      r_sync2;
  logic [2:0]      r_last;
  logic [2:0]      r_clean;
  logic [2:0]      r_clean_d;
  logic [DB_W-1:0] r_db_cnt [3];
  logic [2:0]      w_press;

  logic [WIDTH-1:0] r_entropy;
  logic [WIDTH-1:0] w_seed_next;
  logic [RUN_W-1:0] r_run_cnt;
  logic             r_stop_pending;

  state_t           r_state;
  logic             r_lfsr_load;
  logic             r_lfsr_enable;
  logic [WIDTH-1:0] r_seed;
  logic             r_result_latch;
  logic             r_result_valid;

  logic w_ev_clear;
  logic w_ev_stop;
  logic w_ev_start;
  logic w_stop_now;

  assign w_keys = {key_clear, key_stop, key_start};

  // The stability counter watches the synchronised level one cycle late (r_last),
  // so the clean level only follows after DEBOUNCE_CYCLES unchanged samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_last    <= '0;
      r_clean   <= '0;
      r_clean_d <= '0;
      for (int k = 0; k < 3; k++) begin
        r_db_cnt[k] <= '0;
      end
    end else begin
      r_sync1   <= w_keys;
      r_sync2   <= r_sync1;
      r_last    <= r_sync2;
      r_clean_d <= r_clean;
      for (int k = 0; k < 3; k++) begin
        if (r_sync2[k] != r_last[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] != DB_MAX) begin
          r_db_cnt[k] <= r_db_cnt[k] + DB_W'(1);
        end
        if ((r_sync2[k] == r_last[k]) && (r_db_cnt[k] == DB_MAX)) begin
          r_clean[k] <= r_sync2[k];
        end
      end
    end
  end

  assign w_press = r_clean & ~r_clean_d;

  // Only the highest-priority event survives a same-cycle collision.
  assign w_ev_clear = w_press[2];
  assign w_ev_stop  = w_press[1] & ~w_press[2];
  assign w_ev_start = w_press[0] & ~w_press[1] & ~w_press[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_entropy <= '0;
    end else begin
      r_entropy <= r_entropy + WIDTH'(1);
    end
  end

  // An all-zero seed would lock the LFSR up, so it is replaced by 1.
  assign w_seed_next = (r_entropy == '0) ? WIDTH'(1) : r_entropy;

  assign w_stop_now = (w_ev_stop && (r_run_cnt >= RUN_MAX)) ||
                      (r_stop_pending && (r_run_cnt == RUN_MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_lfsr_load    <= 1'b0;
      r_lfsr_enable  <= 1'b0;
      r_seed         <= '0;
      r_result_latch <= 1'b0;
      r_result_valid <= 1'b0;
      r_run_cnt      <= '0;
      r_stop_pending <= 1'b0;
    end else begin
      r_lfsr_load    <= 1'b0;
      r_result_latch <= 1'b0;
      if (w_ev_clear) begin
        r_state        <= IDLE;
        r_lfsr_enable  <= 1'b0;
        r_result_valid <= 1'b0;
        r_stop_pending <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_ev_start) begin
              r_state     <= SEED;
              r_lfsr_load <= 1'b1;
              r_seed      <= w_seed_next;
            end
          end
          SEED: begin
            r_state        <= RUN;
            r_lfsr_enable  <= 1'b1;
            r_run_cnt      <= '0;
            r_stop_pending <= 1'b0;
          end
          RUN: begin
            if (r_run_cnt != RUN_MAX) begin
              r_run_cnt <= r_run_cnt + RUN_W'(1);
            end
            if (w_stop_now) begin
              r_state        <= STOPPING;
              r_lfsr_enable  <= 1'b0;
              r_result_latch <= 1'b1;
            end else if (w_ev_stop) begin
              r_stop_pending <= 1'b1;
            end
          end
          STOPPING: begin
            r_state        <= SHOW;
            r_result_valid <= 1'b1;
          end
          SHOW: begin
            if (w_ev_start) begin
              r_state        <= SEED;
              r_result_valid <= 1'b0;
              r_lfsr_load    <= 1'b1;
              r_seed         <= w_seed_next;
            end
          end
          default: begin
            r_state        <= IDLE;
            r_lfsr_enable  <= 1'b0;
            r_result_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign lfsr_load    = r_lfsr_load;
  assign lfsr_enable  = r_lfsr_enable;
  assign seed_out     = r_seed;
  assign result_latch = r_result_latch;
  assign result_valid = r_result_valid;
  assign state_out    = r_state;

endmodule

// File: tb/tb_rng_key_sequencer.sv
// Bench for rng_key_sequencer: edge-numbered vector table for the main flow plus
// hand-written glitch, reset and seed-wrap sequences.
module tb_rng_key_sequencer;

  localparam int DB = 4;
  localparam int MR = 8;

  logic        clk = 1'b0;
  logic        reset, key_start, key_stop, key_clear;
  logic        lfsr_load, lfsr_enable, result_latch, result_valid;
  logic [15:0] seed_out;
  logic [2:0]  state_out;

  logic        w4_reset, w4_start, w4_stop, w4_clear;
  logic        w4_load, w4_enable, w4_latch, w4_valid;
  logic [3:0]  w4_seed;
  logic [2:0]  w4_state;

  always #5 clk = ~clk;

  rng_key_sequencer #(.WIDTH(16), .DEBOUNCE_CYCLES(DB), .MIN_RUN_CYCLES(MR)) dut (
    .clk(clk), .reset(reset), .key_start(key_start), .key_stop(key_stop),
    .key_clear(key_clear), .lfsr_load(lfsr_load), .lfsr_enable(lfsr_enable),
    .seed_out(seed_out), .result_latch(result_latch), .result_valid(result_valid),
    .state_out(state_out)
  );

  rng_key_sequencer #(.WIDTH(4), .DEBOUNCE_CYCLES(DB), .MIN_RUN_CYCLES(MR)) dut_w4 (
    .clk(clk), .reset(w4_reset), .key_start(w4_start), .key_stop(w4_stop),
    .key_clear(w4_clear), .lfsr_load(w4_load), .lfsr_enable(w4_enable),
    .seed_out(w4_seed), .result_latch(w4_latch), .result_valid(w4_valid),
    .state_out(w4_state)
  );

  typedef struct packed {
    logic        load;
    logic        en;
    logic        latch;
    logic        valid;
    logic [2:0]  state;
    logic        seed_chk;
    logic [15:0] seed;
  } exp_t;

  typedef struct {
    int   edge_n;
    logic st;
    logic sp;
    logic cl;
    exp_t exp;
  } vec_t;

  localparam int NV = 20;
  vec_t        vecs [NV];
  logic [23:0] exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic exp_t mk(input logic ld, en, la, va, input logic [2:0] s,
                              input logic sc, input logic [15:0] sd);
    exp_t e;
    e.load = ld; e.en = en; e.latch = la; e.valid = va;
    e.state = s; e.seed_chk = sc; e.seed = sd;
    return e;
  endfunction

  task automatic set_vec(input int i, input int e, input logic st, sp, cl, input exp_t x);
    vecs[i].edge_n = e;
    vecs[i].st = st;
    vecs[i].sp = sp;
    vecs[i].cl = cl;
    vecs[i].exp = x;
  endtask

  function automatic exp_t act16();
    return mk(lfsr_load, lfsr_enable, result_latch, result_valid, state_out, 1'b0, seed_out);
  endfunction

  function automatic exp_t act4();
    return mk(w4_load, w4_enable, w4_latch, w4_valid, w4_state, 1'b0, {12'd0, w4_seed});
  endfunction

  task automatic compare(input string name, input exp_t a);
    exp_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: no expected entry queued", name);
      return;
    end
    e = exp_t'(exp_q.pop_front());
    if (a.load !== e.load || a.en !== e.en || a.latch !== e.latch ||
        a.valid !== e.valid || a.state !== e.state ||
        (e.seed_chk && a.seed !== e.seed)) begin
      n_err++;
      $display("FAIL %s: got ld=%b en=%b la=%b va=%b st=%0d seed=%0d, want ld=%b en=%b la=%b va=%b st=%0d seed=%0d%s",
               name, a.load, a.en, a.latch, a.valid, a.state, a.seed,
               e.load, e.en, e.latch, e.valid, e.state, e.seed,
               e.seed_chk ? "" : "(seed not checked)");
    end
  endtask

  task automatic compare_int(input string name, input int act, input int want);
    n_vec++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  // Leaves the bench at a negedge; the next posedge is edge 1.
  task automatic do_reset();
    reset = 1'b1;
    key_start = 1'b0; key_stop = 1'b0; key_clear = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   vi;
    bit   chk;
    int   loads;
    exp_t z;
    z = mk(0, 0, 0, 0, 3'd0, 1'b1, 16'd0);

    reset = 1'b1; key_start = 1'b0; key_stop = 1'b0; key_clear = 1'b0;
    w4_reset = 1'b1; w4_start = 1'b0; w4_stop = 1'b0; w4_clear = 1'b0;

    // Main flow. Inputs take effect at the listed edge; outputs checked just after it.
    set_vec(0,  1,  0, 0, 0, mk(0, 0, 0, 0, 3'd0, 1, 16'd0));
    set_vec(1,  10, 1, 0, 0, mk(0, 0, 0, 0, 3'd0, 0, 16'd0));
    set_vec(2,  15, 1, 1, 0, mk(0, 0, 0, 0, 3'd0, 0, 16'd0));
    set_vec(3,  16, 1, 1, 0, mk(0, 0, 0, 0, 3'd0, 1, 16'd0));
    set_vec(4,  17, 1, 1, 0, mk(1, 0, 0, 0, 3'd1, 1, 16'd16));
    set_vec(5,  18, 1, 1, 0, mk(0, 1, 0, 0, 3'd2, 1, 16'd16));
    set_vec(6,  20, 0, 1, 0, mk(0, 1, 0, 0, 3'd2, 0, 16'd0));
    set_vec(7,  22, 0, 1, 0, mk(0, 1, 0, 0, 3'd2, 0, 16'd0));
    set_vec(8,  25, 0, 0, 0, mk(0, 1, 0, 0, 3'd2, 0, 16'd0));
    set_vec(9,  26, 0, 0, 0, mk(0, 1, 0, 0, 3'd2, 0, 16'd0));
    set_vec(10, 27, 0, 0, 0, mk(0, 0, 1, 0, 3'd3, 0, 16'd0));
    set_vec(11, 28, 0, 0, 0, mk(0, 0, 0, 1, 3'd4, 0, 16'd0));
    set_vec(12, 30, 1, 0, 0, mk(0, 0, 0, 1, 3'd4, 1, 16'd16));
    set_vec(13, 36, 1, 0, 0, mk(0, 0, 0, 1, 3'd4, 0, 16'd0));
    set_vec(14, 37, 1, 0, 0, mk(1, 0, 0, 0, 3'd1, 1, 16'd36));
    set_vec(15, 38, 1, 0, 0, mk(0, 1, 0, 0, 3'd2, 1, 16'd36));
    set_vec(16, 40, 1, 1, 1, mk(0, 1, 0, 0, 3'd2, 0, 16'd0));
    set_vec(17, 46, 1, 1, 1, mk(0, 1, 0, 0, 3'd2, 0, 16'd0));
    set_vec(18, 47, 1, 1, 1, mk(0, 0, 0, 0, 3'd0, 0, 16'd0));
    set_vec(19, 48, 1, 1, 1, mk(0, 0, 0, 0, 3'd0, 0, 16'd0));

    @(posedge clk); #1;
    exp_q.push_back(z);
    compare("reset_state", act16());

    do_reset();
    vi = 0;
    for (int e = 1; e <= 48; e++) begin
      chk = 1'b0;
      if (vi < NV && vecs[vi].edge_n == e) begin
        key_start = vecs[vi].st;
        key_stop  = vecs[vi].sp;
        key_clear = vecs[vi].cl;
        exp_q.push_back(vecs[vi].exp);
        chk = 1'b1;
      end
      @(posedge clk); #1;
      if (chk) begin
        compare($sformatf("flow_e%0d", e), act16());
        vi++;
      end
      @(negedge clk);
    end

    // Glitches shorter than the debounce window must never leave IDLE.
    do_reset();
    for (int p = 1; p <= 3; p++) begin
      key_start = 1'b1;
      repeat (p) @(negedge clk);
      key_start = 1'b0;
      repeat ($urandom_range(12, 16)) @(negedge clk);
      exp_q.push_back(z);
      compare($sformatf("glitch_%0dcyc", p), act16());
    end

    key_start = 1'b1;
    loads = 0;
    for (int c = 0; c < 30; c++) begin
      if (c == 6) key_start = 1'b0;
      @(posedge clk); #1;
      if (lfsr_load) loads++;
      @(negedge clk);
    end
    compare_int("press_6cyc_load_count", loads, 1);
    exp_q.push_back(mk(0, 1, 0, 0, 3'd2, 0, 16'd0));
    compare("press_6cyc_in_run", act16());

    // Reset mid-RUN clears outputs without a clock edge.
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    exp_q.push_back(z);
    compare("async_reset_mid_run", act16());
    @(negedge clk);
    reset = 1'b0;

    // 4-bit entropy wraps to 0 at edge 16: the seed must be forced to 1.
    @(negedge clk);
    w4_reset = 1'b0;
    for (int e = 1; e <= 18; e++) begin
      if (e == 10) w4_start = 1'b1;
      @(posedge clk); #1;
      if (e == 16) begin
        exp_q.push_back(mk(0, 0, 0, 0, 3'd0, 1, 16'd0));
        compare("wrap_e16_idle", act4());
      end else if (e == 17) begin
        exp_q.push_back(mk(1, 0, 0, 0, 3'd1, 1, 16'd1));
        compare("wrap_e17_seed_one", act4());
      end else if (e == 18) begin
        exp_q.push_back(mk(0, 1, 0, 0, 3'd2, 1, 16'd1));
        compare("wrap_e18_run", act4());
      end
      @(negedge clk);
    end

    compare_int("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
